aes_round_iter: RTL and testbench

AES_ROUND_ITER -- requirements
Module: aes_round_iter

---
 rtl/aes_round_iter.sv | 189 ++++++++++++++++++
 tb/tb_aes_round_iter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_iter.sv
// aes_round_iter -- iterative AES encryption core, one round per clock.
//
// The S-box and the key schedule live outside this block: the current state
// is exported on sb_state and its byte-substituted image comes back on
// sb_result; the round key for index rk_idx comes back on rk_in in the same
// cycle. Internally the block does ShiftRows, MixColumns and AddRoundKey.
//
// Parameter:
//   NR          number of rounds (10, 12 or 14)
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       begin encrypting plaintext (only looked at while idle)
//   plaintext   128-bit input block, FIPS byte k at [127-8k -: 8]
//   rk_idx      index of the round key wanted this cycle (0 while idle)
//   rk_in       round key rk_idx, combinational from the key schedule
//   sb_state    current state, sent to the external S-box stage
//   sb_result   S-box image of sb_state, combinational
//   busy        a block is in flight
//   done        one-cycle pulse when ciphertext is updated
//   ciphertext  last result, held until the next completion
//
// Build option:
//   SBOX_PIPE_EN  registers sb_result inside the block and splits every
//                 round into a SUB cycle (capture) and a MIX cycle (apply),
//                 so a block takes 2*NR+1 edges instead of NR+1.
module aes_round_iter #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] sb_state,
  input  logic [127:0] sb_result,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  localparam logic [3:0] LP_LAST = 4'(NR);

`ifdef SBOX_PIPE_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SUB = 2'd1, ST_MIX = 2'd2} fsm_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_t;
`endif

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic [127:0] r_state;
  logic [127:0] r_ct;
  logic [3:0]   r_round;
  logic         r_busy;
  logic         r_done;

  logic [127:0] w_sub;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round_out;
  logic [127:0] w_final;
  logic         w_last;
  logic         w_apply;

`ifdef SBOX_PIPE_EN
  logic [127:0] r_sb;
  assign w_sub   = r_sb;
  assign w_apply = (r_fsm == ST_MIX);
`else
  assign w_sub   = sb_result;
  assign w_apply = (r_fsm == ST_RUN);
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  genvar gi;

  // ShiftRows: output s[r][c] takes input s[r][(c+r) mod 4]; byte index is 4c+r.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_shift
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL + ROW) % 4) + ROW;
      assign w_sr[127-8*gi -: 8] = w_sub[127-8*SRC -: 8];
    end
  endgenerate

  // MixColumns: each column multiplied by the {02,03,01,01} circulant.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      logic [7:0] w_b0, w_b1, w_b2, w_b3;
      assign w_a0 = w_sr[127-32*gi -: 8];
      assign w_a1 = w_sr[119-32*gi -: 8];
      assign w_a2 = w_sr[111-32*gi -: 8];
      assign w_a3 = w_sr[103-32*gi -: 8];
      assign w_b0 = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign w_b1 = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign w_b2 = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign w_b3 = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
      assign w_mc[127-32*gi -: 32] = {w_b0, w_b1, w_b2, w_b3};
    end
  endgenerate

  assign w_round_out = w_mc ^ rk_in;
  assign w_final     = w_sr ^ rk_in;   // last round skips MixColumns
  assign w_last      = (r_round == LP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
`ifdef SBOX_PIPE_EN
      ST_IDLE: if (start) w_fsm_next = ST_SUB;
      ST_SUB:  w_fsm_next = ST_MIX;
      ST_MIX:  w_fsm_next = w_last ? ST_IDLE : ST_SUB;
`else
      ST_IDLE: if (start) w_fsm_next = ST_RUN;
      ST_RUN:  w_fsm_next = w_last ? ST_IDLE : ST_RUN;
`endif
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  // Output logic: key index follows the round counter outside IDLE
  always_comb begin
    rk_idx = 4'd0;
    if (r_fsm != ST_IDLE) begin
      rk_idx = r_round;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_ct    <= '0;
      r_round <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SBOX_PIPE_EN
      r_sb    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_fsm == ST_IDLE) begin
        if (start) begin
          r_state <= plaintext ^ rk_in;
          r_round <= 4'd1;
          r_busy  <= 1'b1;
        end
      end else if (w_apply) begin
        if (w_last) begin
          r_ct    <= w_final;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_round <= 4'd0;
        end else begin
          r_state <= w_round_out;
          r_round <= r_round + 4'd1;
        end
      end
`ifdef SBOX_PIPE_EN
      if (r_fsm == ST_SUB) begin
        r_sb <= sb_result;
      end
`endif
    end
  end

  assign sb_state   = r_state;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ciphertext = r_ct;

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: two instances (NR=14 and NR=10) fed by a
// behavioural S-box table and key-schedule model; expected results are the
// published FIPS-197 vectors.
module tb_aes_round_iter;

`ifdef SBOX_PIPE_EN
  localparam int LAT14 = 29;
  localparam int LAT10 = 21;
  localparam int R1E   = 3;    // edge after which round 1 has been applied
`else
  localparam int LAT14 = 15;
  localparam int LAT10 = 11;
  localparam int R1E   = 2;
`endif

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R0_OUT  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] R1_128  = 128'h89d810e8855ace682d1843d8cb128fe4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start14, start10;
  logic [127:0] pt14, pt10;
  logic [3:0]   rk_idx14, rk_idx10;
  logic [127:0] rk_in14, rk_in10;
  logic [127:0] sb_state14, sb_state10;
  logic [127:0] sb_res14, sb_res10;
  logic         busy14, busy10, done14, done10;
  logic [127:0] ct14, ct10;

  logic [7:0]   sbox_tbl [0:255];
  logic [127:0] rk14_tbl [0:14];
  logic [127:0] rk10_tbl [0:10];
  logic [31:0]  kw [0:59];
  logic         ovr10;
  logic [127:0] w_sub14, w_sub10;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt14 = 0;

  always #5 clk = ~clk;

  aes_round_iter #(.NR(14)) dut14 (
    .clk(clk), .rst_n(rst_n), .start(start14), .plaintext(pt14),
    .rk_idx(rk_idx14), .rk_in(rk_in14), .sb_state(sb_state14),
    .sb_result(sb_res14), .busy(busy14), .done(done14), .ciphertext(ct14)
  );

  aes_round_iter #(.NR(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .plaintext(pt10),
    .rk_idx(rk_idx10), .rk_in(rk_in10), .sb_state(sb_state10),
    .sb_result(sb_res10), .busy(busy10), .done(done10), .ciphertext(ct10)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign w_sub14[127-8*gi -: 8] = sbox_tbl[sb_state14[127-8*gi -: 8]];
      assign w_sub10[127-8*gi -: 8] = sbox_tbl[sb_state10[127-8*gi -: 8]];
    end
  endgenerate

  assign sb_res14 = w_sub14;
  assign sb_res10 = ovr10 ? {4{32'hdb135345}} : w_sub10;
  assign rk_in14  = (rk_idx14 <= 4'd14) ? rk14_tbl[rk_idx14] : '0;
  assign rk_in10  = ovr10 ? '0 : ((rk_idx10 <= 4'd10) ? rk10_tbl[rk_idx10] : '0);

  always @(negedge clk) begin
    if (done14) done_cnt14 <= done_cnt14 + 1;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, xb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tbl[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = kw[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      kw[i] = kw[i-nk] ^ t;
    end
  endtask

  function automatic logic sel_done(input int sel);
    return (sel == 14) ? done14 : done10;
  endfunction
  function automatic logic sel_busy(input int sel);
    return (sel == 14) ? busy14 : busy10;
  endfunction
  function automatic logic [3:0] sel_rk(input int sel);
    return (sel == 14) ? rk_idx14 : rk_idx10;
  endfunction
  function automatic logic [127:0] sel_state(input int sel);
    return (sel == 14) ? sb_state14 : sb_state10;
  endfunction
  function automatic logic [127:0] sel_ct(input int sel);
    return (sel == 14) ? ct14 : ct10;
  endfunction

  // Called just after edge 1 of a run; follows it to completion.
  task automatic finish_run(input int sel, input string tag, input logic [127:0] exp_ct,
                            input int exp_lat, input bit probe);
    int edges = 1;
    int exp_rk;
    while (!sel_done(sel) && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (probe && edges <= 3) begin
`ifdef SBOX_PIPE_EN
        exp_rk = (edges + 1) / 2;
`else
        exp_rk = edges;
`endif
        check_val($sformatf("%s_rk_e%0d", tag, edges), sel_rk(sel), exp_rk);
      end
      if (probe && sel == 10 && edges == R1E) check_val({tag, "_round1"}, sel_state(sel), R1_128);
    end
    check_val({tag, "_lat"}, edges, exp_lat);
    check_val({tag, "_ct"}, sel_ct(sel), exp_ct);
    check_val({tag, "_busy_done"}, sel_busy(sel), 0);
    @(posedge clk); #1;
    check_val({tag, "_done_pulse"}, sel_done(sel), 0);
  endtask

  task automatic run_enc(input int sel, input logic [127:0] exp_ct, input int exp_lat,
                         input string tag);
    @(negedge clk);
    if (sel == 14) begin pt14 = FIPS_PT; start14 = 1'b1; end
    else           begin pt10 = FIPS_PT; start10 = 1'b1; end
    @(posedge clk); #1;
    start14 = 1'b0;
    start10 = 1'b0;
    check_val({tag, "_rk_e1"}, sel_rk(sel), 1);
    check_val({tag, "_busy"}, sel_busy(sel), 1);
    check_val({tag, "_round0"}, sel_state(sel), R0_OUT);
    finish_run(sel, tag, exp_ct, exp_lat, 1'b1);
  endtask

  task automatic busy_start_test();
    int c0;
    int edges = 1;
    c0 = done_cnt14;
    @(negedge clk);
    pt14 = FIPS_PT;
    start14 = 1'b1;
    @(posedge clk); #1;
    start14 = 1'b0;
    while (!done14 && edges < 100) begin
      @(negedge clk);
      start14 = (rk_idx14 == 4'd3) || (rk_idx14 == 4'd9);
      @(posedge clk); #1;
      start14 = 1'b0;
      edges++;
    end
    check_val("ign_lat", edges, LAT14);
    check_val("ign_ct", ct14, CT256);
    // start raised during the done cycle must launch a new run
    start14 = 1'b1;
    @(posedge clk); #1;
    start14 = 1'b0;
    check_val("restart_rk", rk_idx14, 1);
    check_val("restart_busy", busy14, 1);
    check_val("ign_one_done", done_cnt14 - c0, 1);
    finish_run(14, "restart", CT256, LAT14, 1'b0);
  endtask

  task automatic reset_test();
    int c0;
    @(negedge clk);
    start14 = 1'b1;
    @(posedge clk); #1;
    start14 = 1'b0;
    for (int i = 0; i < 80 && rk_idx14 != 4'd7; i++) @(negedge clk);
    check_val("rst_reach7", rk_idx14, 7);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_busy", busy14, 0);
    check_val("rst_done", done14, 0);
    check_val("rst_ct", ct14, 0);
    check_val("rst_rk", rk_idx14, 0);
    check_val("rst_state", sb_state14, 0);
    c0 = done_cnt14;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("rst_no_done", done_cnt14 - c0, 0);
    check_val("rst_ct_held", ct14, 0);
    // start in the same cycle as reset release is taken
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start14 = 1'b1;
    @(posedge clk); #1;
    start14 = 1'b0;
    check_val("rel_start_rk", rk_idx14, 1);
    finish_run(14, "rel", CT256, LAT14, 1'b0);
  endtask

  task automatic mix_test();
    @(negedge clk);
    ovr10 = 1'b1;
    pt10 = 128'h0123456789abcdeffedcba9876543210;
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    check_val("mix_key0", sb_state10, 128'h0123456789abcdeffedcba9876543210);
    repeat (R1E - 1) @(posedge clk);
    #1;
    check_val("mix_col", sb_state10, {4{32'h8e4da1bc}});
    @(negedge clk);
    rst_n = 1'b0;
    ovr10 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    start14 = 1'b0;
    start10 = 1'b0;
    ovr10   = 1'b0;
    pt14    = '0;
    pt10    = '0;
    build_sbox();
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f}, 8, 14);
    for (int r = 0; r <= 14; r++) rk14_tbl[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
    expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) rk10_tbl[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};

    repeat (3) @(negedge clk);
    check_val("reset_busy", busy14, 0);
    check_val("reset_done", done14, 0);
    check_val("reset_ct", ct14, 0);
    check_val("reset_rk", rk_idx14, 0);
    check_val("reset_state", sb_state14, 0);
    rst_n = 1'b1;

    run_enc(14, CT256, LAT14, "aes256");
    run_enc(10, CT128, LAT10, "aes128");
    busy_start_test();
    reset_test();
    mix_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
